// File: rtl/exu_alu_md.sv
// Execute-stage ALU with iterative unsigned multiply and restoring divide.
// Latency: single-cycle ops and DIVU-by-zero 1 edge; MULU/DIVU WIDTH edges after accept.
// Backpressure: in_ready is low while MUL/DIV iterate; flush aborts without a result.
module exu_alu_md #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic [WIDTH-1:0] pc,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             t,
    output logic             t_we_n,
    output logic             div0
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_PC   = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t               state_q;
    logic [SHW-1:0]       cnt_q;
    logic [2*WIDTH-1:0]   acc_q;      // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     b_q;        // multiplicand or divisor captured at accept
    logic                 out_valid_q;
    logic [WIDTH-1:0]     res_q;
    logic [WIDTH-1:0]     res_hi_q;
    logic                 t_q;
    logic                 t_we_n_q;
    logic                 div0_q;

    logic [SHW-1:0]       sh;
    logic                 accept;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_sets_t;
    logic                 alu_t;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   acc_d;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready && !flush;
    assign sh       = op_y[SHW-1:0];

    // Single-cycle result and T-flag computation from the live operands.
    always_comb begin
        alu_res    = op_x;
        alu_sets_t = 1'b0;
        alu_t      = 1'b0;
        case (op)
            OP_ADD:  alu_res = op_x + op_y;
            OP_SUB:  alu_res = op_x - op_y;
            OP_AND:  alu_res = op_x & op_y;
            OP_OR:   alu_res = op_x | op_y;
            OP_SLL:  alu_res = op_x << sh;
            OP_SRL:  alu_res = op_x >> sh;
            OP_SRA:  alu_res = WIDTH'($signed(op_x) >>> sh);
            OP_SLT: begin
                alu_sets_t = 1'b1;
                alu_t      = ($signed(op_x) < $signed(op_y));
            end
            OP_CMP: begin
                alu_sets_t = 1'b1;
                alu_t      = (op_x != op_y);
            end
            OP_PC:   alu_res = pc;
            default: alu_res = op_x;
        endcase
    end

    // One iteration step of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, b_q};
        acc_d    = acc_q;
        if (state_q == S_MUL) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (state_q == S_DIV) begin
            if (!div_diff[WIDTH+1]) begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Control FSM with registered result, flag and strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_hi_q    <= '0;
            t_q         <= 1'b0;
            t_we_n_q    <= 1'b1;
            div0_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            t_we_n_q    <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        div0_q <= 1'b0;
                        cnt_q  <= '0;
                        b_q    <= op_y;
                        if (op == OP_MULU) begin
                            acc_q   <= {{WIDTH{1'b0}}, op_x};
                            state_q <= S_MUL;
                        end else if (op == OP_DIVU && op_y == '0) begin
                            out_valid_q <= 1'b1;
                            res_q       <= '1;
                            res_hi_q    <= op_x;
                            div0_q      <= 1'b1;
                        end else if (op == OP_DIVU) begin
                            acc_q   <= {{WIDTH{1'b0}}, op_x};
                            state_q <= S_DIV;
                        end else begin
                            out_valid_q <= 1'b1;
                            res_hi_q    <= '0;
                            if (alu_sets_t) begin
                                t_q      <= alu_t;
                                t_we_n_q <= 1'b0;
                            end else begin
                                res_q <= alu_res;
                            end
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + SHW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= S_IDLE;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            res_q       <= acc_d[WIDTH-1:0];
                            res_hi_q    <= acc_d[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign t         = t_q;
    assign t_we_n    = t_we_n_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_exu_alu_md.sv
module tb_exu_alu_md;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] op_x = '0;
    logic [W-1:0] op_y = '0;
    logic [W-1:0] pc = 16'h1000;
    logic         out_valid;
    logic [W-1:0] res;
    logic [W-1:0] res_hi;
    logic         t;
    logic         t_we_n;
    logic         div0;

    int tests = 0;
    int fails = 0;

    exu_alu_md #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_x(op_x), .op_y(op_y), .pc(pc),
        .out_valid(out_valid), .res(res), .res_hi(res_hi),
        .t(t), .t_we_n(t_we_n), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        op = o;
        op_x = x;
        op_y = y;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 16'h0 || res_hi !== 16'h0 ||
            t !== 1'b0 || t_we_n !== 1'b1 || div0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b ov=%b res=%h hi=%h t=%b twen=%b div0=%b, want 1 0 0000 0000 0 1 0",
                     in_ready, out_valid, res, res_hi, t, t_we_n, div0);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(4'd0, 16'h7FFF, 16'h0001);
        tick();
        tests++;
        if (out_valid !== 1'b1 || res !== 16'h8000) begin
            fails++;
            $display("FAIL add: ov=%b res=%h, want 1 8000", out_valid, res);
        end
        drive(4'd1, 16'h0000, 16'h0001);
        tick();
        tests++;
        if (out_valid !== 1'b1 || res !== 16'hFFFF || res_hi !== 16'h0) begin
            fails++;
            $display("FAIL sub: ov=%b res=%h hi=%h, want 1 ffff 0000", out_valid, res, res_hi);
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || res !== 16'hFFFF) begin
            fails++;
            $display("FAIL b2b_idle: ov=%b res=%h, want 0 ffff", out_valid, res);
        end
    endtask

    task automatic test_logic_shift();
        logic [3:0]   ops [6];
        logic [W-1:0] xs  [6];
        logic [W-1:0] ys  [6];
        logic [W-1:0] exp [6];
        ops = '{4'd6, 4'd5, 4'd2, 4'd3, 4'd10, 4'd4};
        xs  = '{16'h8000, 16'h8000, 16'hF0F0, 16'hF000, 16'h1234, 16'h0001};
        ys  = '{16'h0003, 16'h0008, 16'h3C3C, 16'h000F, 16'h9999, 16'h000F};
        exp = '{16'hF000, 16'h0080, 16'h3030, 16'hF00F, 16'h1000, 16'h8000};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], xs[i], ys[i]);
            tick();
            tests++;
            if (out_valid !== 1'b1 || res !== exp[i] || t_we_n !== 1'b1) begin
                fails++;
                $display("FAIL alu_op%0d: ov=%b res=%h twen=%b, want 1 %h 1", ops[i], out_valid, res, t_we_n, exp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_slt_cmp();
        drive(4'd7, 16'hFFFF, 16'h0001);
        tick();
        tests++;
        if (out_valid !== 1'b1 || t !== 1'b1 || t_we_n !== 1'b0 || res !== 16'h8000) begin
            fails++;
            $display("FAIL slt: ov=%b t=%b twen=%b res=%h, want 1 1 0 8000", out_valid, t, t_we_n, res);
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (t_we_n !== 1'b1 || t !== 1'b1) begin
            fails++;
            $display("FAIL slt_hold: twen=%b t=%b, want 1 1", t_we_n, t);
        end
        drive(4'd8, 16'h0005, 16'h0005);
        tick();
        tests++;
        if (t !== 1'b0 || t_we_n !== 1'b0 || res !== 16'h8000) begin
            fails++;
            $display("FAIL cmp_eq: t=%b twen=%b res=%h, want 0 0 8000", t, t_we_n, res);
        end
        drive(4'd8, 16'h0001, 16'h0002);
        tick();
        tests++;
        if (t !== 1'b1 || t_we_n !== 1'b0) begin
            fails++;
            $display("FAIL cmp_ne: t=%b twen=%b, want 1 0", t, t_we_n);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic run_iter(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] elo, input logic [W-1:0] ehi, input string name);
        int bad;
        drive(o, x, y);
        tick();
        in_valid = 1'b0;
        op_x = 16'hDEAD;
        op_y = 16'hBEEF;
        bad = 0;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        for (int k = 1; k < W; k++) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_busy: %0d busy cycles wrong, want 0", name, bad);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || res !== elo || res_hi !== ehi || div0 !== 1'b0) begin
            fails++;
            $display("FAIL %s_result: ov=%b rdy=%b res=%h hi=%h div0=%b, want 1 1 %h %h 0",
                     name, out_valid, in_ready, res, res_hi, div0, elo, ehi);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_pulse: ov=%b, want 0", name, out_valid);
        end
    endtask

    task automatic test_div0();
        drive(4'd12, 16'h00FF, 16'h0000);
        tick();
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || res !== 16'hFFFF || res_hi !== 16'h00FF || div0 !== 1'b1) begin
            fails++;
            $display("FAIL div0: ov=%b rdy=%b res=%h hi=%h div0=%b, want 1 1 ffff 00ff 1",
                     out_valid, in_ready, res, res_hi, div0);
        end
        drive(4'd0, 16'h0001, 16'h0001);
        tick();
        tests++;
        if (div0 !== 1'b0 || res !== 16'h0002 || res_hi !== 16'h0000) begin
            fails++;
            $display("FAIL div0_clear: div0=%b res=%h hi=%h, want 0 0002 0000", div0, res, res_hi);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int bad;
        drive(4'd11, 16'h0003, 16'h0003);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 16'h0002 || res_hi !== 16'h0000) begin
            fails++;
            $display("FAIL flush_mul: rdy=%b ov=%b res=%h hi=%h, want 1 0 0002 0000", in_ready, out_valid, res, res_hi);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL flush_no_result: %0d out_valid cycles, want 0", bad);
        end
        drive(4'd0, 16'h0010, 16'h0010);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || res !== 16'h0002) begin
            fails++;
            $display("FAIL flush_idle: ov=%b res=%h, want 0 0002", out_valid, res);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        int bad;
        drive(4'd8, 16'h0001, 16'h0002);
        tick();
        drive(4'd12, 16'd100, 16'd7);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 16'h0 || res_hi !== 16'h0 ||
            t !== 1'b0 || t_we_n !== 1'b1 || div0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_div: rdy=%b ov=%b res=%h hi=%h t=%b twen=%b div0=%b, want 1 0 0000 0000 0 1 0",
                     in_ready, out_valid, res, res_hi, t, t_we_n, div0);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_abandon: %0d bad cycles after reset, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_logic_shift();
        test_slt_cmp();
        run_iter(4'd11, 16'h1234, 16'h0010, 16'h2340, 16'h0001, "mulu");
        run_iter(4'd11, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, "mulu_max");
        run_iter(4'd12, 16'd100, 16'd7, 16'd14, 16'd2, "divu");
        run_iter(4'd12, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, "divu_big");
        test_div0();
        test_flush();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exu_alu_md.md
# exu_alu_md

Parametrised execute-stage arithmetic unit for the 16-bit CPU core. It extends single-cycle add/logic/shift/compare with an iterative multiplier and divider. A valid/ready handshake lets the pipeline stall while a multi-cycle operation runs. The instruction decoder supplies a decoded op code and already-muxed operands (register or extended immediate), and the unit returns a registered result plus the T-flag update.

## Interface
- WIDTH, 16: datapath width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from op_y.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous abort of any accepted, uncompleted operation.
- in_valid  in  1  op/op_x/op_y/pc are valid.
- in_ready  out  1  unit can accept; high exactly when state is IDLE.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 SLT, 8 CMP, 9 PASSX, 10 PC, 11 MULU, 12 DIVU; 13-15 behave as PASSX.
- op_x, op_y  in  WIDTH  operands.
- pc  in  WIDTH  current PC, used by op PC.
- out_valid  out  1  one-cycle pulse: res/res_hi/t are new.
- res  out  WIDTH  result; product low half, or quotient.
- res_hi  out  WIDTH  product high half, or remainder; 0 for other ops.
- t  out  1  T flag value.
- t_we_n  out  1  active-low T write strobe, coincident with out_valid.
- div0  out  1  set with out_valid on DIVU with op_y==0; cleared on the next accept.

## Operation
- Accept happens on a rising edge with in_valid && in_ready && !flush.
- States:
  - IDLE: single-cycle ops are computed and registered at the accept edge. MULU goes to MUL and DIVU goes to DIV. DIVU with op_y==0 stays in IDLE and completes at once.
  - MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
  - DIV: restoring division, one quotient bit per cycle.
  - Leave MUL/DIV to IDLE when the step counter reaches WIDTH-1.
- Arithmetic is mod 2^WIDTH. Carry and overflow are discarded.
- SLL/SRL/SRA shift by op_y[SHW-1:0]. The decoder maps immediate 0 to 8 before this unit.
- SRA replicates op_x[WIDTH-1].
- SLT: t = signed(op_x) < signed(op_y).
- CMP: t = (op_x != op_y).
- For SLT and CMP, t_we_n=0 and res holds its previous value.
- All other ops: t holds and t_we_n=1.
- DIVU by zero: res = all ones, res_hi = op_x, div0 = 1.
- res/res_hi/t hold between completions.
- flush:
  - In MUL/DIV: return to IDLE, no out_valid, res/res_hi/t unchanged.
  - In IDLE: blocks acceptance that edge.
- Async reset mid-operation abandons the op immediately. Reset values: state IDLE, in_ready 1, out_valid 0, res 0, res_hi 0, t 0, t_we_n 1, div0 0, counter 0.

## Timing
- Single-cycle op accepted at edge N: out_valid high from edge N to edge N+1.
- Back-to-back single-cycle ops sustain one result per cycle.
- MULU/DIVU accepted at edge N: in_ready low from N, out_valid from edge N+WIDTH for one cycle, in_ready high from edge N+WIDTH.
- A new op can be accepted at edge N+WIDTH.
- Operands are captured at accept. op_x/op_y may change during MUL/DIV.
- in_ready is combinational from state only, with no path from in_valid.
- flush and accept on the same edge: flush wins, op not accepted.
- out_valid is never asserted for two consecutive cycles from one op.

## Test plan
- Reset, then WIDTH=16, ADD 0x7FFF+0x0001 -> res 0x8000 next cycle. Then SUB 0x0000-0x0001 -> 0xFFFF. out_valid high on 2 consecutive cycles.
- SRA 0x8000 by 3 -> 0xF000. SRL 0x8000 by 8 -> 0x0080. SLL 0x0001 by 15 -> 0x8000.
- SLT 0xFFFF vs 0x0001 -> t=1, t_we_n low 1 cycle, res unchanged. CMP 5 vs 5 -> t=0.
- MULU 0x1234 × 0x0010 -> res 0x2340, res_hi 0x0001. out_valid exactly 16 cycles after accept. in_ready low for those 16 cycles.
- DIVU 100/7 -> res 14, res_hi 2 after 16 cycles. DIVU 0x00FF/0 -> res 0xFFFF, res_hi 0x00FF, div0=1, 1-cycle latency.
- MULU accepted, flush on the 5th busy cycle -> no out_valid, in_ready high next cycle, res holds old value. Repeat with rst low mid-DIV -> all outputs at reset values immediately.
